// File: rtl/axis_frame_source.sv
// AXI-Stream frame source: one command (length, seed, mode) yields one TLAST-terminated frame.
// Optional INTER_FRAME_GAP_EN inserts GAP_CYCLES idle cycles after every completed frame.
module axis_frame_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [LEN_WIDTH-1:0]  cmdLength,
  input  logic [DATA_WIDTH-1:0] cmdSeed,
  input  logic [1:0]            cmdMode,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutTValid,
  input  logic                  dataOutTReady,
  output logic                  dataOutTLast,
  output logic [3:0]            dataOutTStrb,
  output logic                  busy,
  output logic                  frameDone,
  output logic [15:0]           framesSent
);

  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(32'hA3000000);

`ifdef INTER_FRAME_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} stateT;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} stateT;
`endif

  stateT                 state, stateNext;
  logic [LEN_WIDTH-1:0]  remain, remainNext;
  logic [1:0]            mode, modeNext;
  logic [DATA_WIDTH-1:0] dataNext;
  logic                  validNext, lastNext, cmdReadyNext, busyNext, frameDoneNext;
  logic [3:0]            strbNext;
  logic [15:0]           framesSentNext;
`ifdef INTER_FRAME_GAP_EN
  logic [7:0]            gapCnt, gapNext;
`endif

  // Modes 0 and 3 both increment; 2 is a right-shifting Galois LFSR.
  function automatic logic [DATA_WIDTH-1:0] nextWord(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] m);
    case (m)
      2'd1:    return w;
      2'd2:    return (w >> 1) ^ (w[0] ? LFSR_TAPS : '0);
      default: return w + DATA_WIDTH'(1);
    endcase
  endfunction

  always_comb begin
    stateNext      = state;
    remainNext     = remain;
    modeNext       = mode;
    dataNext       = dataOut;
    validNext      = dataOutTValid;
    lastNext       = dataOutTLast;
    strbNext       = dataOutTStrb;
    cmdReadyNext   = cmdReady;
    busyNext       = busy;
    frameDoneNext  = 1'b0;
    framesSentNext = framesSent;
`ifdef INTER_FRAME_GAP_EN
    gapNext        = gapCnt;
`endif
    case (state)
      IDLE: begin
        cmdReadyNext = 1'b1;
        busyNext     = 1'b0;
        if (cmdValid && cmdReady) begin
          if (cmdLength != '0) begin
            stateNext    = SEND;
            remainNext   = cmdLength;
            modeNext     = cmdMode;
            // An all-zero LFSR state would lock up, so seed 0 becomes 1.
            dataNext     = (cmdMode == 2'd2 && cmdSeed == '0) ? DATA_WIDTH'(1) : cmdSeed;
            validNext    = 1'b1;
            lastNext     = (cmdLength == LEN_WIDTH'(1));
            strbNext     = 4'b1111;
            cmdReadyNext = 1'b0;
            busyNext     = 1'b1;
          end else begin
            frameDoneNext  = 1'b1;
            framesSentNext = framesSent + 16'd1;
`ifdef INTER_FRAME_GAP_EN
            stateNext      = GAP;
            gapNext        = 8'(GAP_CYCLES);
            cmdReadyNext   = 1'b0;
            busyNext       = 1'b1;
`endif
          end
        end
      end
      SEND: begin
        if (dataOutTValid && dataOutTReady) begin
          if (remain == LEN_WIDTH'(1)) begin
            validNext      = 1'b0;
            lastNext       = 1'b0;
            strbNext       = 4'b0000;
            frameDoneNext  = 1'b1;
            framesSentNext = framesSent + 16'd1;
`ifdef INTER_FRAME_GAP_EN
            stateNext      = GAP;
            gapNext        = 8'(GAP_CYCLES);
`else
            stateNext      = IDLE;
            cmdReadyNext   = 1'b1;
            busyNext       = 1'b0;
`endif
          end else begin
            remainNext = remain - LEN_WIDTH'(1);
            dataNext   = nextWord(dataOut, mode);
            lastNext   = (remain == LEN_WIDTH'(2));
          end
        end
      end
`ifdef INTER_FRAME_GAP_EN
      // The frameDone cycle is the first of the GAP_CYCLES gap cycles.
      GAP: begin
        cmdReadyNext = 1'b0;
        busyNext     = 1'b1;
        if (gapCnt <= 8'd1) begin
          stateNext    = IDLE;
          cmdReadyNext = 1'b1;
          busyNext     = 1'b0;
        end else begin
          gapNext = gapCnt - 8'd1;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state         <= IDLE;
      remain        <= '0;
      mode          <= '0;
      dataOut       <= '0;
      dataOutTValid <= 1'b0;
      dataOutTLast  <= 1'b0;
      dataOutTStrb  <= 4'b0000;
      cmdReady      <= 1'b0;
      busy          <= 1'b0;
      frameDone     <= 1'b0;
      framesSent    <= 16'd0;
`ifdef INTER_FRAME_GAP_EN
      gapCnt        <= 8'd0;
`endif
    end else begin
      state         <= stateNext;
      remain        <= remainNext;
      mode          <= modeNext;
      dataOut       <= dataNext;
      dataOutTValid <= validNext;
      dataOutTLast  <= lastNext;
      dataOutTStrb  <= strbNext;
      cmdReady      <= cmdReadyNext;
      busy          <= busyNext;
      frameDone     <= frameDoneNext;
      framesSent    <= framesSentNext;
`ifdef INTER_FRAME_GAP_EN
      gapCnt        <= gapNext;
`endif
    end
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Scoreboarded random bench for axis_frame_source: stimulus pushes expected beats, a negedge monitor pops them.
module tb_axis_frame_source;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int GAPC = 4;
`ifdef INTER_FRAME_GAP_EN
  localparam int MINGAP = 6;
`else
  localparam int MINGAP = 2;
`endif

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic [LW-1:0] cmdLength = '0;
  logic [DW-1:0] cmdSeed = '0;
  logic [1:0]    cmdMode = '0;
  logic [DW-1:0] dataOut;
  logic          dataOutTValid;
  logic          dataOutTReady = 1'b0;
  logic          dataOutTLast;
  logic [3:0]    dataOutTStrb;
  logic          busy;
  logic          frameDone;
  logic [15:0]   framesSent;

  axis_frame_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_CYCLES(GAPC)) dut (
    .clock(clock), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdLength(cmdLength), .cmdSeed(cmdSeed), .cmdMode(cmdMode),
    .dataOut(dataOut), .dataOutTValid(dataOutTValid), .dataOutTReady(dataOutTReady),
    .dataOutTLast(dataOutTLast), .dataOutTStrb(dataOutTStrb), .busy(busy),
    .frameDone(frameDone), .framesSent(framesSent)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beatT;

  beatT expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   expCompleted = 0;
  int   xferCount = 0;
  int   readyMode = 0;
  int   pidx = 0;
  bit   pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] refNext(input logic [31:0] w, input logic [1:0] m);
    if (m == 2'd1) return w;
    if (m == 2'd2) return (w >> 1) ^ (w[0] ? 32'hA3000000 : 32'h0);
    return w + 32'd1;
  endfunction

  // Monitor: every transfer pops one expected beat; stalled beats must hold.
  initial begin
    logic        prevStall;
    logic [31:0] prevData;
    logic        prevLast;
    bit          inFrame;
    int          lastFinal;
    beatT        b;
    prevStall = 1'b0; prevData = '0; prevLast = 1'b0; inFrame = 0; lastFinal = -1;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        prevStall = 1'b0; inFrame = 0; lastFinal = -1;
      end else begin
        if (frameDone) begin
          check("framesSent_at_done", framesSent, 16'(expCompleted));
`ifdef INTER_FRAME_GAP_EN
          check("cmdReady_at_done", cmdReady, 1'b0);
`else
          check("cmdReady_at_done", cmdReady, 1'b1);
`endif
        end
        if (prevStall) begin
          check("hold_valid", dataOutTValid, 1'b1);
          check("hold_data_last", {dataOutTLast, dataOut}, {prevLast, prevData});
        end
        if (dataOutTValid && dataOutTReady) begin
          if (!inFrame && lastFinal >= 0) check("frame_spacing_ok", 64'(cyc - lastFinal >= MINGAP), 1);
          inFrame = 1;
          if (expQ.size() == 0) begin
            check("unexpected_beat", dataOutTValid, 1'b0);
          end else begin
            b = expQ.pop_front();
            check("beat_data", dataOut, b.data);
            check("beat_last", dataOutTLast, b.last);
            check("beat_strb", dataOutTStrb, 4'hF);
            if (b.last) begin
              expCompleted++;
              inFrame = 0;
              lastFinal = cyc;
            end
          end
          xferCount++;
        end
        prevStall = dataOutTValid && !dataOutTReady;
        prevData  = dataOut;
        prevLast  = dataOutTLast;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    case (readyMode)
      0: dataOutTReady = 1'b1;
      1: begin dataOutTReady = pattern[pidx % 6]; pidx++; end
      2: dataOutTReady = 1'($urandom_range(0, 1));
      default: dataOutTReady = 1'b0;
    endcase
  endtask

  task automatic issue(input int len, input logic [31:0] seed, input logic [1:0] mode);
    int n;
    logic [31:0] w;
    beatT b;
    n = 0;
    cmdValid = 1'b1; cmdLength = len[15:0]; cmdSeed = seed; cmdMode = mode;
    while (!cmdReady && n < 3000) begin tick(); n++; end
    if (!cmdReady) begin
      check("cmd_accept_timeout", cmdReady, 1'b1);
      cmdValid = 1'b0;
      return;
    end
    w = (mode == 2'd2 && seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < len; i++) begin
      b.data = w; b.last = (i == len - 1);
      expQ.push_back(b);
      w = refNext(w, mode);
    end
    pidx = 0;
    tick();
    cmdValid = 1'b0;
    check("first_beat_latency", dataOutTValid, 64'(len > 0));
    if (len == 0) expCompleted++;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy) && n < 5000) begin tick(); n++; end
    check("drain_timeout", 64'(expQ.size() != 0 || busy), 0);
    tick();
  endtask

  initial begin
    int base, n, len;
    logic [31:0] seed;
    // Reset held for 3 cycles
    resetN = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", {cmdReady, busy, frameDone, dataOutTValid, dataOutTLast, dataOutTStrb}, 0);
    check("reset_data", dataOut, 0);
    check("reset_framesSent", framesSent, 0);
    resetN = 1'b1;
    tick();
    check("cmdReady_after_reset", cmdReady, 1'b1);
    check("busy_after_reset", busy, 1'b0);

    // Incrementing frame under continuous ready
    readyMode = 0;
    issue(4, 32'h10, 2'd0);
    waitIdle();
    check("framesSent_t2", framesSent, 16'd1);

    // LFSR with seed 0 and toggling ready
    readyMode = 1;
    issue(3, 32'h0, 2'd2);
    waitIdle();
    readyMode = 0;
    check("framesSent_t3", framesSent, 16'd2);

    // Zero-length command
    issue(0, 32'h55, 2'd1);
`ifdef INTER_FRAME_GAP_EN
    check("cmdReady_after_len0", cmdReady, 1'b0);
`else
    check("cmdReady_after_len0", cmdReady, 1'b1);
`endif
    waitIdle();
    check("framesSent_t4", framesSent, 16'd3);

    // Reset mid-frame after 37 transfers
    base = xferCount;
    issue(100, 32'hDEADBEEF, 2'd1);
    n = 0;
    while (xferCount < base + 37 && n < 500) begin tick(); n++; end
    check("xfers_before_reset", xferCount - base, 37);
    resetN = 1'b0;
    readyMode = 3;
    dataOutTReady = 1'b0;
    tick();
    check("midreset_valid", dataOutTValid, 1'b0);
    check("midreset_last", dataOutTLast, 1'b0);
    check("midreset_framesSent", framesSent, 16'd0);
    expQ.delete();
    expCompleted = 0;
    resetN = 1'b1;
    readyMode = 0;
    tick();
    issue(2, 32'h1234, 2'd0);
    waitIdle();
    check("framesSent_after_reset", framesSent, 16'd1);

    // Back-to-back length-2 frames (spacing checked by monitor)
    issue(2, 32'hA0, 2'd0);
    issue(2, 32'hB0, 2'd3);
    waitIdle();

    // Length-1 boundary frame
    issue(1, 32'hFFFFFFFF, 2'd0);
    waitIdle();

    // Randomized commands with random backpressure, issued back-to-back
    for (int k = 0; k < 30; k++) begin
      readyMode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 20));
      seed = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      issue(len, seed, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) tick();
    end
    readyMode = 0;
    waitIdle();
    check("framesSent_final", framesSent, 16'(expCompleted));
    check("queue_empty_final", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
AXI-Stream transmitter that produces 32-bit test/data frames on command and drives the input side of the stream FIFO (dataIn/TValid/TReady/TLast/TStrb). A single command (length, seed, mode) yields exactly one TLAST-terminated frame, with full TREADY backpressure support. The block is the frame source for FIFO bring-up on PYNQ and for loopback checking against a matching sink.

Parameters:
DATA_WIDTH, 32, stream data width; the LFSR mode requires 32.
LEN_WIDTH, 16, width of the frame length field in beats.
GAP_CYCLES, 4, idle cycles inserted after each frame. Used only when INTER_FRAME_GAP_EN is defined; range 1..255.

Ports:
clock  input  1  single clock for all logic.
resetN  input  1  synchronous, active-low reset.
cmdValid  input  1  command request.
cmdReady  output  1  high only in IDLE; the command is accepted when cmdValid and cmdReady are both high.
cmdLength  input  LEN_WIDTH  frame length in beats; 0 is legal and produces no beats.
cmdSeed  input  DATA_WIDTH  first data word.
cmdMode  input  2  0 = incrementing, 1 = constant, 2 = LFSR, 3 = incrementing (reserved).
dataOut  output  DATA_WIDTH  stream data.
dataOutTValid  output  1  stream valid.
dataOutTReady  input  1  downstream ready.
dataOutTLast  output  1  high on the final beat of a frame.
dataOutTStrb  output  4  byte strobes.
busy  output  1  high whenever the state is not IDLE.
frameDone  output  1  one-cycle pulse when a frame completes.
framesSent  output  16  count of completed frames, wraps modulo 2^16.

Behaviour:
- Reset is sampled only on the rising edge of clock while resetN=0. Outputs in reset:
  - cmdReady=0, busy=0, frameDone=0, framesSent=0.
  - dataOut=0, dataOutTValid=0, dataOutTLast=0, dataOutTStrb=0.
  - state=IDLE.
- cmdReady rises on the first clock after reset is released.
- All outputs are registered.
- State machine: IDLE, SEND, GAP. GAP exists only with the macro defined.
- IDLE:
  - cmdReady=1.
  - On command acceptance with cmdLength>0: latch length, mode and seed; load dataOut=seed (seed 0 in LFSR mode is replaced by 1). Set dataOutTValid=1, dataOutTLast=(cmdLength==1), dataOutTStrb=4'b1111, cmdReady=0. Go to SEND.
  - First beat is valid 1 cycle after acceptance.
  - Acceptance with cmdLength=0: no beats are emitted. frameDone pulses the next cycle, framesSent increments, and the state stays IDLE. With the macro defined, go to GAP instead.
- SEND:
  - A beat transfers on a clock where dataOutTValid and dataOutTReady are both high.
  - Without a transfer, dataOut, dataOutTLast and dataOutTValid hold stable. dataOutTValid never drops before its handshake.
  - On a non-final transfer: the remaining count decrements, and the next word is presented on the very next cycle, giving 1 beat/cycle under continuous TREADY. Next word by mode:
    - incrementing: word+1, modulo 2^32.
    - constant: word unchanged.
    - LFSR: (word>>1) ^ (word[0] ? 32'hA3000000 : 0).
  - dataOutTLast=1 exactly when the remaining count is 1.
  - On the final transfer: dataOutTValid=0, dataOutTLast=0, dataOutTStrb=0, frameDone=1 for one cycle, framesSent+1. Go to IDLE, with cmdReady=1 on the same cycle frameDone is high.
  - Minimum spacing between frames is therefore 1 cycle with dataOutTValid low.
- Commands presented while not in IDLE are not accepted; cmdValid may remain high.
- Length wrap: the down-counter is LEN_WIDTH bits. The maximum frame is 2^LEN_WIDTH-1 beats. framesSent wraps 0xFFFF to 0x0000.
- Reset mid-frame: on the next clock dataOutTValid=0 and all outputs take their reset values. A partial frame is abandoned without TLAST. This is the only sanctioned way a frame is truncated.
- dataOutTReady is ignored while dataOutTValid=0.

Optional Feature:
Macro INTER_FRAME_GAP_EN.
- Defined: after a frame completes (or after a zero-length command), the FSM enters GAP for GAP_CYCLES cycles.
  - In GAP, busy=1, cmdReady=0, dataOutTValid=0.
  - Then go to IDLE.
  - frameDone and the framesSent increment still occur on the cycle after the final transfer.
- Undefined: the GAP state and its counter are not built, and completion returns directly to IDLE.

Test Plan:
1. Reset with resetN=0 for 3 cycles, then release -> all outputs are 0 during reset; cmdReady=1 on the first cycle after release; busy=0.
2. Length=4, seed=0x10, mode 0, TREADY held 1 -> dataOut 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles starting 1 cycle after acceptance. TLAST only on 0x13. frameDone pulses once; framesSent=1.
3. Length=3, mode 2, seed=0, TREADY toggling 1,0,0,1,0,1 -> beats 0x00000001, 0xA3000000, 0x51800000. Data and TLAST hold stable while TREADY=0; TVALID never drops mid-frame.
4. Length=0 command -> no TVALID. frameDone pulses once; framesSent increments; cmdReady=1 again 1 cycle later (macro undefined).
5. Length=100, mode 1, seed=0xDEADBEEF; assert resetN=0 after 37 transfers -> TVALID=0 on the next clock, framesSent=0, no TLAST observed. A new length=2 command after reset completes normally.
6. With INTER_FRAME_GAP_EN and GAP_CYCLES=4, two back-to-back length=2 commands -> cmdReady stays low for 4 cycles after frameDone, and the second frame's first beat is ≥6 cycles after the first frame's final transfer.
